// File: rtl/exe_pkg.sv
// Shared types and constants for the execution-unit command sequencer.
package exe_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } seq_state_t;

    localparam int STAT_EVEN = 0;
    localparam int STAT_ONES = 1;
    localparam int STAT_OVF  = 2;
    localparam int STAT_ERR  = 3;

    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    function automatic logic [3:0] tag_next(input logic [3:0] t);
        return t + 4'd1;
    endfunction

endpackage

// File: rtl/exe_cmd_sequencer_if.sv
// Command and response valid/ready handshakes of the sequencer.
interface exe_cmd_sequencer_if #(
    parameter int M = 8
);

    logic         i_cmd_valid;
    logic         o_cmd_ready;
    logic [1:0]   i_cmd_op;
    logic [M-1:0] i_cmd_argA;
    logic [M-1:0] i_cmd_argB;
    logic         o_rsp_valid;
    logic         i_rsp_ready;
    logic [M-1:0] o_rsp_result;
    logic [3:0]   o_rsp_stat;
    logic [3:0]   o_rsp_tag;

    modport master (
        output i_cmd_valid,
        output i_cmd_op,
        output i_cmd_argA,
        output i_cmd_argB,
        output i_rsp_ready,
        input  o_cmd_ready,
        input  o_rsp_valid,
        input  o_rsp_result,
        input  o_rsp_stat,
        input  o_rsp_tag
    );

    modport slave (
        input  i_cmd_valid,
        input  i_cmd_op,
        input  i_cmd_argA,
        input  i_cmd_argB,
        input  i_rsp_ready,
        output o_cmd_ready,
        output o_rsp_valid,
        output o_rsp_result,
        output o_rsp_stat,
        output o_rsp_tag
    );

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; full/empty come from the registered count only.
module cmd_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign o_full  = (count_q == CNT_FULL);
    assign o_empty = (count_q == '0);
    assign o_rdata = mem_q[rptr_q];
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            mem_d[wptr_q] = i_wdata;
            wptr_d        = wptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + PTR_ONE;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/exe_cmd_sequencer.sv
// Issues buffered commands to the execution unit one at a time and
// returns each registered result with a sequence tag.
module exe_cmd_sequencer
    import exe_pkg::*;
#(
    parameter int M     = 8,
    parameter int DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    exe_cmd_sequencer_if.slave   bus,
    output logic [1:0]           o_op,
    output logic [M-1:0]         o_argA,
    output logic [M-1:0]         o_argB,
    input  logic [M-1:0]         i_result,
    input  logic [3:0]           i_stat,
    output logic [7:0]           o_err_cnt,
    output logic                 o_busy
);

    localparam int W = 2 + 2*M;

    seq_state_t   state_q, state_d;
    logic [1:0]   op_q, op_d;
    logic [M-1:0] arga_q, arga_d;
    logic [M-1:0] argb_q, argb_d;
    logic [M-1:0] rsp_result_q, rsp_result_d;
    logic [3:0]   rsp_stat_q, rsp_stat_d;
    logic [3:0]   rsp_tag_q, rsp_tag_d;
    logic [3:0]   tag_q, tag_d;
    logic [7:0]   err_cnt_q, err_cnt_d;

    logic         push;
    logic         load;
    logic         capture;
    logic         full;
    logic         empty;
    logic [W-1:0] head;

    assign push = bus.i_cmd_valid && bus.o_cmd_ready;

    cmd_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (push),
        .i_wdata ({bus.i_cmd_op, bus.i_cmd_argA, bus.i_cmd_argB}),
        .i_pop   (load),
        .o_rdata (head),
        .o_full  (full),
        .o_empty (empty)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    load    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (bus.i_rsp_ready) begin
                    if (!empty) begin
                        load    = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Drive registers change only on a load; response registers on capture.
    always_comb begin
        op_d         = op_q;
        arga_d       = arga_q;
        argb_d       = argb_q;
        rsp_result_d = rsp_result_q;
        rsp_stat_d   = rsp_stat_q;
        rsp_tag_d    = rsp_tag_q;
        tag_d        = tag_q;
        err_cnt_d    = err_cnt_q;
        if (load) begin
            op_d   = head[W-1 -: 2];
            arga_d = head[2*M-1 -: M];
            argb_d = head[M-1:0];
        end
        if (capture) begin
            rsp_result_d = i_result;
            rsp_stat_d   = i_stat;
            rsp_tag_d    = tag_q;
            tag_d        = tag_next(tag_q);
            if (i_stat[STAT_ERR] && (err_cnt_q != ERR_CNT_MAX)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= IDLE;
            op_q         <= '0;
            arga_q       <= '0;
            argb_q       <= '0;
            rsp_result_q <= '0;
            rsp_stat_q   <= '0;
            rsp_tag_q    <= '0;
            tag_q        <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            arga_q       <= arga_d;
            argb_q       <= argb_d;
            rsp_result_q <= rsp_result_d;
            rsp_stat_q   <= rsp_stat_d;
            rsp_tag_q    <= rsp_tag_d;
            tag_q        <= tag_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.o_cmd_ready  = !full;
    assign bus.o_rsp_valid  = (state_q == RESP);
    assign bus.o_rsp_result = rsp_result_q;
    assign bus.o_rsp_stat   = rsp_stat_q;
    assign bus.o_rsp_tag    = rsp_tag_q;

    assign o_op      = op_q;
    assign o_argA    = arga_q;
    assign o_argB    = argb_q;
    assign o_err_cnt = err_cnt_q;
    assign o_busy    = !empty || (state_q != IDLE);

endmodule

// File: doc/exe_cmd_sequencer.md
# exe_cmd_sequencer

Command front-end for the M-bit execution unit. Accepts (op, argA, argB) commands over a valid/ready handshake and buffers them in a small FIFO. Issues them one at a time to the execution unit's operand/op inputs, captures the registered result and 4-bit status one cycle later, and returns them tagged over a second valid/ready handshake. Sits directly upstream of the execution unit and consumes its outputs, so the unit's 1-cycle register latency is hidden from the command source.

## Interface
- M, 8, operand/result width (must match the execution unit)
- DEPTH, 4, command FIFO entries (power of two, >= 2)
- i_clk  in  1  clock; single clock domain
- i_reset  in  1  asynchronous, active-low reset (asserted = 0)
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  FIFO can accept
- i_cmd_op  in  2  operation select, passed unchanged
- i_cmd_argA / i_cmd_argB  in  M  operands
- o_op  out  2  to execution unit i_op
- o_argA / o_argB  out  M  to execution unit i_argA / i_argB
- i_result  in  M  from execution unit o_result
- i_stat  in  4  from execution unit o_stat: [0] EVEN, [1] ONES, [2] OVERFLOW, [3] ERROR
- o_rsp_valid  out  1  response held
- i_rsp_ready  in  1  consumer takes response
- o_rsp_result  out  M  captured result
- o_rsp_stat  out  4  captured status
- o_rsp_tag  out  4  issue sequence number, wraps 15 -> 0
- o_err_cnt  out  8  count of responses with stat[3] = 1, saturates at 255
- o_busy  out  1  FIFO non-empty or state != IDLE

## Operation
- FIFO push on i_cmd_valid && o_cmd_ready. o_cmd_ready = (count != DEPTH), from registered count only, never from pop.
- A simultaneous push and pop leaves count unchanged. A pop happens only when the FIFO is non-empty.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if the FIFO is non-empty, at the edge load o_op/o_argA/o_argB from the head, pop, and go to ISSUE.
  - ISSUE: drive registers stable while the execution unit registers the computation. Go unconditionally to WAIT.
  - WAIT: i_result/i_stat are valid. At the edge, capture them into the o_rsp_result/o_rsp_stat registers, load o_rsp_tag from the tag counter, increment the tag counter, update o_err_cnt, and go to RESP.
  - RESP: o_rsp_valid = 1. Hold all rsp outputs until i_rsp_ready.
    - On handshake with the FIFO non-empty: load the next head into the drive registers, pop, go to ISSUE.
    - On handshake with the FIFO empty: go to IDLE.
    - Without a handshake: stay in RESP.
- Drive registers hold their last value in IDLE/RESP and change only on a load.
- At most one command is in flight. Commands keep FIFO order, with no reordering.
- o_err_cnt increments by 1 at the WAIT capture when i_stat[3] = 1. It stays at 255 once reached.

## Timing
- Reset (i_reset = 0, asynchronous): FIFO empty, FSM IDLE, tag counter 0.
  - Outputs: o_op = 0, o_argA = o_argB = 0, o_rsp_valid = 0, o_rsp_result = 0, o_rsp_stat = 0, o_rsp_tag = 0, o_err_cnt = 0, o_busy = 0, o_cmd_ready = 1.
- Reset mid-operation discards the in-flight command and all queued commands. No response is produced for them.
- The execution unit is tied to the same i_clk and i_reset.
- Latency: a command accepted at edge N into an empty, idle block is driven after N+1, registered by the execution unit at N+2, and appears with o_rsp_valid = 1 after N+3.
- Throughput: one response per 3 cycles with i_rsp_ready held high (RESP -> ISSUE -> WAIT -> RESP).
- o_cmd_ready may be 0 for consecutive cycles while the FIFO is full. The source must hold its payload stable while i_cmd_valid = 1 and o_cmd_ready = 0.

## Structure
- Shared package exe_pkg:
  - typedef enum logic [1:0] seq_state_t {IDLE, ISSUE, WAIT, RESP}
  - localparams STAT_EVEN = 0, STAT_ONES = 1, STAT_OVF = 2, STAT_ERR = 3
  - localparam ERR_CNT_MAX = 8'd255
- Sub-module cmd_fifo #(W, DEPTH): synchronous FIFO with push/pop, full/empty, and the same asynchronous active-low reset. W = 2 + 2*M.
- The FSM, drive registers, response registers and counters live in the top module.

## Test plan
- Single command, op = 2, A = 8'h05, B = 8'h03, with i_result stubbed to 8'h2A and i_stat to 4'b0001 -> o_rsp_valid rises exactly 3 cycles after acceptance, rsp_result = 8'h2A, rsp_stat = 4'b0001, tag = 0.
- Push 5 back-to-back commands with i_rsp_ready = 0 -> o_cmd_ready drops after the 5th accept (1 in flight + 4 queued). The 6th command is held until the first response handshake, then accepted. Responses come out in order with tags 0..5.
- Hold i_rsp_ready low for 10 cycles in RESP -> all rsp outputs and o_argA/o_argB stay stable, and no pop occurs.
- 300 commands with i_stat[3] = 1 -> o_err_cnt reads 255 and does not wrap; tag sequence wraps 15 -> 0.
- Assert i_reset = 0 during WAIT with 3 commands queued -> all outputs at reset values immediately. After release, no response for the flushed commands, and a new command gets tag 0.
- Continuous source and sink, 20 commands -> 20 responses in 60 cycles (steady state), with o_busy high throughout and low one cycle after the last handshake.
